// File: rtl/wb_pkg.sv
// wb_pkg: shared widths, write request type and zero-register constant for the write-back path.
package wb_pkg;
  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;
  localparam logic [WB_ADDR_W-1:0] WB_ZERO_REG = 5'd0;
  typedef struct packed {
    logic [WB_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: DEPTH-entry synchronous FIFO of write requests with asynchronous active-high reset.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  wb_req_t       din_i,
  output wb_req_t       head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);
  wb_req_t mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] count_q, count_d;
  always_comb begin
    wr_d = push_i ? wr_q + 1'b1 : wr_q;
    rd_d = pop_i ? rd_q + 1'b1 : rd_q;
    count_d = count_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk)
    if (push_i) mem_q[wr_q] <= din_i;
  assign head_o = mem_q[rd_q];
  assign full_o = count_q == (AW+1)'(DEPTH);
  assign empty_o = count_q == '0;
  assign count_o = count_q;
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges pipeline write-back (A) and buffered long-latency writes (B) onto one register-file port.
// Define WB_ARB_STARVE_EN to bound B starvation to MAX_WAIT A issues; otherwise A has strict priority.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [WB_ADDR_W-1:0]    a_rd,
  input  logic [WB_DATA_W-1:0]    a_data,
  input  logic                    b_valid,
  output logic                    b_ready,
  input  logic [WB_ADDR_W-1:0]    b_rd,
  input  logic [WB_DATA_W-1:0]    b_data,
  output logic                    WE,
  output logic [WB_ADDR_W-1:0]    Rw,
  output logic [WB_DATA_W-1:0]    busW,
  output logic [$clog2(DEPTH):0]  b_count,
  output logic                    pending
);
  wb_req_t head;
  logic full, empty, push, pop, force_b, a_issue;
  logic we_q, we_d;
  logic [WB_ADDR_W-1:0] rw_q, rw_d;
  logic [WB_DATA_W-1:0] busw_q, busw_d;
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (CLK),
    .rst     (RST),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   ({b_rd, b_data}),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (b_count)
  );
  assign pending = !empty;
`ifdef WB_ARB_STARVE_EN
  logic [7:0] wait_q, wait_d;
  assign force_b = (wait_q == 8'(MAX_WAIT)) && pending;
  always_comb
    wait_d = (pop || empty) ? '0 : (a_issue && wait_q != 8'(MAX_WAIT)) ? wait_q + 8'd1 : wait_q;
  always_ff @(posedge CLK or posedge RST)
    if (RST) wait_q <= '0;
    else wait_q <= wait_d;
`else
  assign force_b = 1'b0;
`endif
  assign a_ready = !RST && !force_b;
  assign b_ready = !RST && !full;
  assign a_issue = a_valid && a_ready && a_rd != WB_ZERO_REG;
  // force_b blocks A, so the head issues whenever A does not take the slot.
  assign pop = pending && !a_issue;
  assign push = b_valid && b_ready && b_rd != WB_ZERO_REG;
  always_comb begin
    we_d = a_issue || pop;
    rw_d = a_issue ? a_rd : pop ? head.rd : rw_q;
    busw_d = a_issue ? a_data : pop ? head.data : busw_q;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      we_q <= 1'b0;
      rw_q <= '0;
      busw_q <= '0;
    end else begin
      we_q <= we_d;
      rw_q <= rw_d;
      busw_q <= busw_d;
    end
  assign WE = we_q;
  assign Rw = rw_q;
  assign busW = busw_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed stimulus with a write scoreboard for wb_arbiter (DEPTH=4, MAX_WAIT=8).
module tb_wb_arbiter;
  logic CLK, RST, a_valid, a_ready, b_valid, b_ready, WE, pending;
  logic [4:0] a_rd, b_rd, Rw;
  logic [31:0] a_data, b_data, busW;
  logic [2:0] b_count;
  int checks = 0;
  int failures = 0;
  logic [36:0] exp_q [$];
`ifdef WB_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  wb_arbiter #(.DEPTH(4), .MAX_WAIT(8)) dut (
    .CLK(CLK), .RST(RST),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .WE(WE), .Rw(Rw), .busW(busW), .b_count(b_count), .pending(pending)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #2;
  endtask

  always @(negedge CLK) begin
    logic [36:0] e;
    if (WE === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL sb_unexpected observed Rw=%0d busW=%h expected no write", Rw, busW);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        assert ({Rw, busW} === e) else begin
          failures++;
          $error("FAIL sb_write observed Rw=%0d busW=%h expected Rw=%0d busW=%h", Rw, busW, e[36:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    int n;
    bit exp_rdy;
    RST = 1'b1; a_valid = 0; a_rd = 0; a_data = 0; b_valid = 0; b_rd = 0; b_data = 0;
    #3;
    chk("rst_we", WE, 0); chk("rst_rw", Rw, 0); chk("rst_busw", busW, 0);
    chk("rst_count", b_count, 0); chk("rst_pending", pending, 0);
    chk("rst_a_ready", a_ready, 0); chk("rst_b_ready", b_ready, 0);
    cyc();
    RST = 1'b0;
    // A only
    a_valid = 1; a_rd = 5; a_data = 32'hDEADBEEF; exp_q.push_back({5'd5, 32'hDEADBEEF});
    cyc();
    chk("a0_we", WE, 1); chk("a0_rw", Rw, 5);
    a_rd = 6; a_data = 32'd1; exp_q.push_back({5'd6, 32'd1});
    cyc();
    chk("a1_we", WE, 1); chk("a1_rw", Rw, 6); chk("a1_busw", busW, 1);
    a_valid = 0;
    cyc();
    chk("a_idle_we", WE, 0); chk("a_hold_rw", Rw, 6); chk("a_hold_busw", busW, 1);
    // B latency: pushed at one edge, issued at the next
    b_valid = 1; b_rd = 9; b_data = 32'h99; exp_q.push_back({5'd9, 32'h99});
    cyc();
    b_valid = 0;
    chk("b_lat_count", b_count, 1); chk("b_lat_pending", pending, 1); chk("b_lat_we0", WE, 0);
    cyc();
    chk("b_lat_we1", WE, 1); chk("b_lat_rw", Rw, 9); chk("b_lat_count0", b_count, 0);
    // B fill while A holds the port
    for (int i = 0; i < 5; i++) begin
      a_valid = 1; a_rd = 7; a_data = 32'h70 + i; exp_q.push_back({5'd7, 32'h70 + i});
      b_valid = (i < 4); b_rd = 5'(10 + i); b_data = 32'hB0 + i;
      cyc();
    end
    chk("fill_count", b_count, 4); chk("fill_b_ready", b_ready, 0);
    for (int i = 0; i < 4; i++) exp_q.push_back({5'(10 + i), 32'hB0 + i});
    a_valid = 0; b_valid = 1; b_rd = 14; b_data = 32'hEE;
    cyc();
    b_valid = 0;
    chk("full_no_push_count", b_count, 3); chk("drain_rw", Rw, 10);
    cyc(); cyc(); cyc();
    chk("drain_count", b_count, 0); chk("drain_pending", pending, 0);
    // Starvation bound
    n = 0;
    b_valid = 1; b_rd = 2; b_data = 32'h222;
    a_valid = 1; a_rd = 1;
    for (int c = 0; c < 12; c++) begin
      a_data = 32'h100 + n;
      exp_rdy = !(STARVE && c == 9);
      chk("starve_a_ready", a_ready, exp_rdy);
      if (exp_rdy) begin
        exp_q.push_back({5'd1, 32'h100 + n});
        n++;
      end else exp_q.push_back({5'd2, 32'h222});
      cyc();
      b_valid = 0;
      if (!exp_rdy) chk("starve_b_rw", Rw, 2);
    end
    a_valid = 0;
    if (!STARVE) exp_q.push_back({5'd2, 32'h222});
    chk("starve_pending", pending, !STARVE);
    cyc(); cyc();
    chk("starve_done", pending, 0);
    // Register 0 on A frees the slot for the FIFO head
    a_valid = 1; a_rd = 4; a_data = 32'h444; exp_q.push_back({5'd4, 32'h444});
    b_valid = 1; b_rd = 3; b_data = 32'h333;
    cyc();
    b_valid = 0; a_rd = 0; a_data = 32'hDEAD0000;
    chk("r0a_a_ready", a_ready, 1); chk("r0a_count", b_count, 1);
    exp_q.push_back({5'd3, 32'h333});
    cyc();
    a_valid = 0;
    chk("r0a_we", WE, 1); chk("r0a_rw", Rw, 3); chk("r0a_busw", busW, 32'h333); chk("r0a_count0", b_count, 0);
    // Register 0 on B is discarded
    b_valid = 1; b_rd = 0; b_data = 32'h55;
    chk("r0b_b_ready", b_ready, 1);
    cyc();
    b_valid = 0;
    chk("r0b_count", b_count, 0); chk("r0b_pending", pending, 0);
    cyc();
    chk("r0b_we", WE, 0);
    // Simultaneous push and pop at b_count=2
    for (int i = 0; i < 2; i++) begin
      a_valid = 1; a_rd = 8; a_data = 32'h80 + i; exp_q.push_back({5'd8, 32'h80 + i});
      b_valid = 1; b_rd = 5'(20 + i); b_data = 32'hC0 + i;
      cyc();
    end
    a_valid = 0; b_rd = 22; b_data = 32'hC2;
    chk("sim_count_pre", b_count, 2);
    for (int i = 0; i < 3; i++) exp_q.push_back({5'(20 + i), 32'hC0 + i});
    cyc();
    b_valid = 0;
    chk("sim_count", b_count, 2); chk("sim_we", WE, 1); chk("sim_rw", Rw, 20); chk("sim_busw", busW, 32'hC0);
    cyc(); cyc();
    chk("sim_drain", b_count, 0);
    // Reset mid-stream with 3 entries queued
    for (int i = 0; i < 3; i++) begin
      a_valid = 1; a_rd = 8; a_data = 32'h90 + i; exp_q.push_back({5'd8, 32'h90 + i});
      b_valid = 1; b_rd = 5'(23 + i); b_data = 32'hD0 + i;
      cyc();
    end
    a_valid = 0; b_valid = 0;
    chk("mid_count", b_count, 3); chk("mid_we", WE, 1);
    @(negedge CLK);
    #1;
    RST = 1'b1;
    #1;
    chk("mid_rst_we", WE, 0); chk("mid_rst_count", b_count, 0); chk("mid_rst_pending", pending, 0);
    chk("mid_rst_a_ready", a_ready, 0); chk("mid_rst_b_ready", b_ready, 0);
    cyc();
    chk("mid_rst_hold_we", WE, 0);
    RST = 1'b0;
    a_valid = 1; a_rd = 31; a_data = 32'h12345678; exp_q.push_back({5'd31, 32'h12345678});
    cyc();
    a_valid = 0;
    chk("post_rst_we", WE, 1); chk("post_rst_rw", Rw, 31);
    cyc(); cyc(); cyc();
    chk("post_rst_idle", WE, 0);
    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
